counter_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one external Sync_counter between NUM_REQ requesters, each needing a timed interval of programmable length. It grants the counter to one requester at a time, loads the requested terminal value, clears and starts the counter, and returns a one-cycle done pulse to the owner when the counter signals its end. The block sits between the requesting control blocks and the single shared counter instance.

---
 rtl/counter_rr_scheduler.sv | 178 +++++++++++++++++
 tb/tb_counter_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
// Round-robin owner of a single shared Sync_counter: grants it to one requester,
// loads and clears it, then returns a one-cycle done pulse when it ends.
module counter_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int counter_bits = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*counter_bits-1:0] len_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            busy_o,
  output logic [counter_bits-1:0]         cnt_limit_o,
  output logic                            cnt_clr_o,
  input  logic                            cnt_end_i
);

  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [IW-1:0]             last_q, last_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic                      busy_q, busy_d;
  logic [counter_bits-1:0]   cnt_limit_q, cnt_limit_d;
  logic                      cnt_clr_q, cnt_clr_d;

  logic [IW:0]               cand;
  logic [IW-1:0]             pick;
  logic                      pick_vld;
  logic [counter_bits-1:0]   pick_len;
  logic                      req_own;

  // Search last+1, last+2, ... wrapping at NUM_REQ; first set request wins.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_vld && req_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_len = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (pick == IW'(i)) begin
        pick_len = len_i[i*counter_bits +: counter_bits];
      end
    end
  end

  assign req_own = req_i[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    grant_d     = grant_q;
    done_d      = '0;
    busy_d      = busy_q;
    cnt_limit_d = cnt_limit_q;
    cnt_clr_d   = cnt_clr_q;

    unique case (state_q)
      IDLE: begin
        grant_d   = '0;
        busy_d    = 1'b0;
        cnt_clr_d = 1'b1;
        if (pick_vld) begin
          state_d       = ARM;
          idx_d         = pick;
          grant_d[pick] = 1'b1;
          busy_d        = 1'b1;
          cnt_limit_d   = pick_len;
        end
      end

      ARM: begin
        if (!req_own) begin
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          cnt_clr_d = 1'b1;
          last_d    = idx_q;
        end else begin
          state_d   = RUN;
          cnt_clr_d = 1'b0;
        end
      end

      RUN: begin
        // End has priority over a simultaneous request drop.
        if (cnt_end_i) begin
          state_d       = DONE;
          grant_d       = '0;
          busy_d        = 1'b0;
          cnt_clr_d     = 1'b1;
          done_d[idx_q] = 1'b1;
          last_d        = idx_q;
        end else if (!req_own) begin
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          cnt_clr_d = 1'b1;
          last_d    = idx_q;
        end
      end

      DONE: begin
        state_d   = IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        cnt_clr_d = 1'b1;
      end

      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        cnt_clr_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= LAST_RST;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cnt_limit_q <= '0;
      cnt_clr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_limit_q <= cnt_limit_d;
      cnt_clr_q   <= cnt_clr_d;
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign cnt_limit_o = cnt_limit_q;
  assign cnt_clr_o   = cnt_clr_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant_q));
  a_done_onehot:  assert property (@(posedge clk) disable iff (!nrst) $onehot0(done_q));
  a_grant_done_excl: assert property (@(posedge clk) disable iff (!nrst)
                                      !((|grant_q) && (|done_q)));

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler with a behavioural Sync_counter attached.
module tb_counter_rr_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req_i;
  logic [31:0] len_i;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic        busy_o;
  logic [7:0]  cnt_limit_o;
  logic        cnt_clr_o;
  logic        cnt_end_i;

  logic [7:0]  cnt_q;
  int          n_cmp = 0;
  int          n_fail = 0;

  counter_rr_scheduler #(.NUM_REQ(4), .counter_bits(8)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_i      (req_i),
    .len_i      (len_i),
    .grant_o    (grant_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .cnt_limit_o(cnt_limit_o),
    .cnt_clr_o  (cnt_clr_o),
    .cnt_end_i  (cnt_end_i)
  );

  always #5 clk = ~clk;

  // External counter: held at 0 while cleared, otherwise increments each cycle.
  always_ff @(posedge clk) cnt_q <= cnt_clr_o ? 8'd0 : cnt_q + 8'd1;
  assign cnt_end_i = !cnt_clr_o && (cnt_q == cnt_limit_o);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [7:0] val);
    len_i[idx*8 +: 8] = val;
  endtask

  task automatic test_reset;
    nrst = 1'b0; req_i = 4'b0000; len_i = '0;
    step; step;
    n_cmp++;
    if ({grant_o, done_o, busy_o, cnt_clr_o} !== 10'b0000_0000_0_1) begin
      n_fail++;
      $display("FAIL reset_outputs: got g=%b d=%b busy=%b clr=%b expected g=0000 d=0000 busy=0 clr=1",
               grant_o, done_o, busy_o, cnt_clr_o);
    end
    n_cmp++;
    if (cnt_limit_o !== 8'd0) begin
      n_fail++; $display("FAIL reset_limit: got %0d expected 0", cnt_limit_o);
    end
    nrst = 1'b1;
    step;
    n_cmp++;
    if ({grant_o, busy_o, cnt_clr_o} !== 6'b0000_0_1) begin
      n_fail++; $display("FAIL idle_no_req: got g=%b busy=%b clr=%b expected 0000/0/1", grant_o, busy_o, cnt_clr_o);
    end
  endtask

  task automatic test_single;
    set_len(0, 8'd5); req_i = 4'b0001;
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o, cnt_clr_o} !== 10'b0001_0000_1_1 || cnt_limit_o !== 8'd5) begin
      n_fail++; $display("FAIL single_arm: got g=%b d=%b busy=%b clr=%b lim=%0d expected 0001/0000/1/1/5",
                         grant_o, done_o, busy_o, cnt_clr_o, cnt_limit_o);
    end
    step;
    n_cmp++;
    if ({grant_o, cnt_clr_o} !== 5'b0001_0) begin
      n_fail++; $display("FAIL single_run_start: got g=%b clr=%b expected 0001/0", grant_o, cnt_clr_o);
    end
    for (int n = 3; n <= 7; n++) begin
      step;
      n_cmp++;
      if ({grant_o, done_o} !== 8'b0001_0000) begin
        n_fail++; $display("FAIL single_run_n%0d: got g=%b d=%b expected 0001/0000", n, grant_o, done_o);
      end
    end
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o, cnt_clr_o} !== 10'b0000_0001_0_1) begin
      n_fail++; $display("FAIL single_done: got g=%b d=%b busy=%b clr=%b expected 0000/0001/0/1",
                         grant_o, done_o, busy_o, cnt_clr_o);
    end
    req_i = 4'b0000;
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o} !== 9'b0000_0000_0) begin
      n_fail++; $display("FAIL single_after: got g=%b d=%b busy=%b expected 0000/0000/0", grant_o, done_o, busy_o);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    int lens[4]  = '{2, 3, 0, 1};
    logic [3:0] exp_g;
    nrst = 1'b0; req_i = 4'b0000;
    step;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) set_len(i, 8'(lens[i]));
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << order[g];
      step;
      n_cmp++;
      if ({grant_o, done_o} !== {exp_g, 4'b0000}) begin
        n_fail++; $display("FAIL rr_grant%0d: got g=%b d=%b expected %b/0000", g, grant_o, done_o, exp_g);
      end
      for (int k = 0; k < lens[order[g]] + 1; k++) begin
        step;
        n_cmp++;
        if ({grant_o, done_o} !== {exp_g, 4'b0000}) begin
          n_fail++; $display("FAIL rr_hold%0d_%0d: got g=%b d=%b expected %b/0000", g, k, grant_o, done_o, exp_g);
        end
      end
      step;
      n_cmp++;
      if ({grant_o, done_o} !== {4'b0000, exp_g}) begin
        n_fail++; $display("FAIL rr_done%0d: got g=%b d=%b expected 0000/%b", g, grant_o, done_o, exp_g);
      end
      if (g == 4) req_i = 4'b0000;
      step;
      n_cmp++;
      if ({grant_o, done_o, busy_o} !== 9'b0000_0000_0) begin
        n_fail++; $display("FAIL rr_idle%0d: got g=%b d=%b busy=%b expected 0000/0000/0", g, grant_o, done_o, busy_o);
      end
    end
  endtask

  task automatic test_abort;
    set_len(2, 8'd10); req_i = 4'b0100;
    step;
    n_cmp++;
    if (grant_o !== 4'b0100) begin
      n_fail++; $display("FAIL abort_grant: got %b expected 0100", grant_o);
    end
    step;
    n_cmp++;
    if (cnt_clr_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_run_clr: got %b expected 0", cnt_clr_o);
    end
    for (int n = 3; n <= 5; n++) begin
      step;
      n_cmp++;
      if ({grant_o, done_o} !== 8'b0100_0000) begin
        n_fail++; $display("FAIL abort_run_n%0d: got g=%b d=%b expected 0100/0000", n, grant_o, done_o);
      end
    end
    req_i = 4'b0000;
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o, cnt_clr_o} !== 10'b0000_0000_0_1) begin
      n_fail++; $display("FAIL abort_idle: got g=%b d=%b busy=%b clr=%b expected 0000/0000/0/1",
                         grant_o, done_o, busy_o, cnt_clr_o);
    end
    set_len(3, 8'd3); req_i = 4'b1011;
    step;
    n_cmp++;
    if ({grant_o, done_o} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL abort_next_ptr: got g=%b d=%b expected 1000/0000", grant_o, done_o);
    end
    req_i = 4'b0000;
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o} !== 9'b0000_0000_0) begin
      n_fail++; $display("FAIL abort_in_arm: got g=%b d=%b busy=%b expected 0000/0000/0", grant_o, done_o, busy_o);
    end
    step;
    n_cmp++;
    if (done_o !== 4'b0000) begin
      n_fail++; $display("FAIL abort_no_done: got %b expected 0000", done_o);
    end
  endtask

  task automatic test_max_len;
    set_len(0, 8'd255); req_i = 4'b0001;
    step;
    n_cmp++;
    if (grant_o !== 4'b0001 || cnt_limit_o !== 8'd255) begin
      n_fail++; $display("FAIL max_grant: got g=%b lim=%0d expected 0001/255", grant_o, cnt_limit_o);
    end
    for (int n = 2; n <= 257; n++) begin
      step;
      n_cmp++;
      if ({grant_o, done_o} !== 8'b0001_0000 || cnt_limit_o !== 8'd255) begin
        n_fail++; $display("FAIL max_run_n%0d: got g=%b d=%b lim=%0d expected 0001/0000/255",
                           n, grant_o, done_o, cnt_limit_o);
      end
    end
    step;
    n_cmp++;
    if ({grant_o, done_o} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL max_done: got g=%b d=%b expected 0000/0001", grant_o, done_o);
    end
    req_i = 4'b0000;
    step;
  endtask

  task automatic test_reset_mid_run;
    set_len(0, 8'd10); req_i = 4'b0001;
    step;
    n_cmp++;
    if (grant_o !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_grant: got %b expected 0001", grant_o);
    end
    step; step; step;
    nrst = 1'b0;
    step;
    n_cmp++;
    if ({grant_o, done_o, busy_o, cnt_clr_o} !== 10'b0000_0000_0_1 || cnt_limit_o !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got g=%b d=%b busy=%b clr=%b lim=%0d expected 0000/0000/0/1/0",
                         grant_o, done_o, busy_o, cnt_clr_o, cnt_limit_o);
    end
    nrst = 1'b1; req_i = 4'b1010;
    step;
    n_cmp++;
    if ({grant_o, done_o} !== 8'b0010_0000) begin
      n_fail++; $display("FAIL rstmid_first_grant: got g=%b d=%b expected 0010/0000", grant_o, done_o);
    end
    req_i = 4'b0000;
    step;
    n_cmp++;
    if ({grant_o, done_o} !== 8'b0000_0000) begin
      n_fail++; $display("FAIL rstmid_abort: got g=%b d=%b expected 0000/0000", grant_o, done_o);
    end
  endtask

  task automatic test_end_vs_abort;
    set_len(1, 8'd2); req_i = 4'b0010;
    step;
    n_cmp++;
    if (grant_o !== 4'b0010 || cnt_limit_o !== 8'd2) begin
      n_fail++; $display("FAIL endab_grant: got g=%b lim=%0d expected 0010/2", grant_o, cnt_limit_o);
    end
    step;
    set_len(1, 8'd7);
    step;
    n_cmp++;
    if (cnt_limit_o !== 8'd2) begin
      n_fail++; $display("FAIL endab_len_change: got %0d expected 2", cnt_limit_o);
    end
    step;
    n_cmp++;
    if (cnt_limit_o !== 8'd2 || done_o !== 4'b0000) begin
      n_fail++; $display("FAIL endab_last_run: got lim=%0d d=%b expected 2/0000", cnt_limit_o, done_o);
    end
    req_i = 4'b0000;
    step;
    n_cmp++;
    if ({grant_o, done_o} !== 8'b0000_0010) begin
      n_fail++; $display("FAIL endab_done: got g=%b d=%b expected 0000/0010", grant_o, done_o);
    end
    step;
    n_cmp++;
    if (done_o !== 4'b0000) begin
      n_fail++; $display("FAIL endab_pulse_width: got %b expected 0000", done_o);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_abort;
    test_max_len;
    test_reset_mid_run;
    test_end_vs_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
